// File: rtl/common_fifo4.sv
// common_fifo4: 4-entry first-word-fall-through FIFO, WIDTH bits per entry.
// Optional feature: define COMMON_FIFO4_ERRFLAG_EN to add the sticky o_err
// overflow/underflow flag. With the macro undefined, the port and its
// register are absent.
module common_fifo4 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_pdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pdata,
  output logic             o_empty,
  output logic             o_full,
  output logic [2:0]       o_count
`ifdef COMMON_FIFO4_ERRFLAG_EN
  ,
  output logic             o_err
`endif
);

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;
  localparam int unsigned CNT_W = 3;

  // 2-bit increment/decrement; the carry out of bit 1 is dropped, so 3 wraps to 0.
  function automatic logic [PTR_W-1:0] decinc2(input logic [PTR_W-1:0] a,
                                               input logic             dec);
    logic [PTR_W-1:0] r;
    if (dec) r = PTR_W'(a - PTR_W'(1));
    else     r = PTR_W'(a + PTR_W'(1));
    return r;
  endfunction

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  logic             w_empty;
  logic             w_full;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [PTR_W-1:0] w_wptr_nxt;
  logic [PTR_W-1:0] w_rptr_nxt;
  logic [CNT_W-1:0] w_count_nxt;

  // Status comes only from the registered occupancy.
  assign w_empty = (r_count == CNT_W'(0));
  assign w_full  = (r_count == CNT_W'(DEPTH));

  // Accept decisions use start-of-cycle state; no same-cycle bypass.
  assign w_push_ok = i_push & ~w_full;
  assign w_pop_ok  = i_pop  & ~w_empty;

  // Next pointer and occupancy values.
  always_comb begin
    w_wptr_nxt  = r_wptr;
    w_rptr_nxt  = r_rptr;
    w_count_nxt = r_count;
    if (w_push_ok) w_wptr_nxt = decinc2(r_wptr, 1'b0);
    if (w_pop_ok)  w_rptr_nxt = decinc2(r_rptr, 1'b0);
    if (w_push_ok && !w_pop_ok)      w_count_nxt = CNT_W'(r_count + CNT_W'(1));
    else if (w_pop_ok && !w_push_ok) w_count_nxt = CNT_W'(r_count - CNT_W'(1));
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Storage: cleared on reset, written on an accepted push; pops leave entries intact.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push_ok) begin
      r_mem[r_wptr] <= i_pdata;
    end
  end

`ifdef COMMON_FIFO4_ERRFLAG_EN
  logic r_err;

  // Sticky flag for any push while full or pop while empty; cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if ((i_push & w_full) | (i_pop & w_empty)) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`endif

  assign o_pdata = r_mem[r_rptr];
  assign o_empty = w_empty;
  assign o_full  = w_full;
  assign o_count = r_count;

endmodule

// File: tb/tb_common_fifo4.sv
// tb_common_fifo4: directed table-driven bench for common_fifo4 (WIDTH=32).
module tb_common_fifo4;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             i_push;
  logic [WIDTH-1:0] i_pdata;
  logic             i_pop;
  logic [WIDTH-1:0] o_pdata;
  logic             o_empty;
  logic             o_full;
  logic [2:0]       o_count;
`ifdef COMMON_FIFO4_ERRFLAG_EN
  logic             o_err;
`endif

  common_fifo4 #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_push  (i_push),
    .i_pdata (i_pdata),
    .i_pop   (i_pop),
    .o_pdata (o_pdata),
    .o_empty (o_empty),
    .o_full  (o_full),
    .o_count (o_count)
`ifdef COMMON_FIFO4_ERRFLAG_EN
    ,
    .o_err   (o_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             rst;
    logic             push;
    logic [WIDTH-1:0] din;
    logic             pop;
    logic [2:0]       cnt;
    logic             emp;
    logic             ful;
    logic [WIDTH-1:0] dout;
    logic             err;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic vec_t mk(input logic rst, input logic push, input logic [WIDTH-1:0] din,
                              input logic pop, input logic [2:0] cnt, input logic [WIDTH-1:0] dout,
                              input logic err);
    vec_t v;
    v.rst = rst; v.push = push; v.din = din; v.pop = pop;
    v.cnt = cnt; v.emp = (cnt == 3'd0); v.ful = (cnt == 3'd4);
    v.dout = dout; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic rst, input logic push, input logic [WIDTH-1:0] din,
                      input logic pop);
    @(negedge clk);
    reset = rst; i_push = push; i_pdata = din; i_pop = pop;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string tag, input int idx, input vec_t v);
    chk({tag, ".count"}, idx, WIDTH'(o_count), WIDTH'(v.cnt));
    chk({tag, ".empty"}, idx, WIDTH'(o_empty), WIDTH'(v.emp));
    chk({tag, ".full"},  idx, WIDTH'(o_full),  WIDTH'(v.ful));
    chk({tag, ".pdata"}, idx, o_pdata, v.dout);
`ifdef COMMON_FIFO4_ERRFLAG_EN
    chk({tag, ".err"},   idx, WIDTH'(o_err), WIDTH'(v.err));
`endif
  endtask

  initial begin
    vec_t v;
    reset = 1'b1; i_push = 1'b0; i_pdata = '0; i_pop = 1'b0;

    // reset, then fill with A1..A4
    vecs.push_back(mk(1, 0, 32'h0,  0, 3'd0, 32'h0,  0));
    vecs.push_back(mk(0, 1, 32'hA1, 0, 3'd1, 32'hA1, 0));
    vecs.push_back(mk(0, 1, 32'hA2, 0, 3'd2, 32'hA1, 0));
    vecs.push_back(mk(0, 1, 32'hA3, 0, 3'd3, 32'hA1, 0));
    vecs.push_back(mk(0, 1, 32'hA4, 0, 3'd4, 32'hA1, 0));
    // full: push FF with pop -> pop only; overflow sets err
    vecs.push_back(mk(0, 1, 32'hFF, 1, 3'd3, 32'hA2, 1));
    vecs.push_back(mk(0, 0, 32'h0,  1, 3'd2, 32'hA3, 1));
    // count 2 (A3,A4): 10 push/pop cycles with data 0..9
    for (int k = 0; k < 10; k++)
      vecs.push_back(mk(0, 1, WIDTH'(k), 1, 3'd2, (k == 0) ? 32'hA4 : WIDTH'(k - 1), 1));
    // drain 8, 9; stale slot 2 then holds 6
    vecs.push_back(mk(0, 0, 32'h0,  1, 3'd1, 32'h9,  1));
    vecs.push_back(mk(0, 0, 32'h0,  1, 3'd0, 32'h6,  1));
    // empty: pop with push 55 -> push only
    vecs.push_back(mk(0, 1, 32'h55, 1, 3'd1, 32'h55, 1));
    vecs.push_back(mk(0, 1, 32'h11, 0, 3'd2, 32'h55, 1));
    vecs.push_back(mk(0, 1, 32'h22, 0, 3'd3, 32'h55, 1));
    // reset at count 3 with push held high
    vecs.push_back(mk(1, 1, 32'h77, 0, 3'd0, 32'h0,  0));
    // pop on empty: ignored, underflow sets err
    vecs.push_back(mk(0, 0, 32'h0,  1, 3'd0, 32'h0,  1));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      step(v.rst, v.push, v.din, v.pop);
      chk_status("vec", i, v);
    end

    // Hand sequence: fresh reset, fill, push while full without pop, then drain in order.
    step(1, 0, 32'h0, 0);
    chk_status("seq_rst", 0, mk(0, 0, 0, 0, 3'd0, 32'h0, 0));
    for (int k = 0; k < 4; k++) begin
      step(0, 1, WIDTH'(32'hC0 + k), 0);
      chk("seq_fill.count", k, WIDTH'(o_count), WIDTH'(k + 1));
    end
    step(0, 1, 32'hDEAD, 0);
    chk_status("seq_ovf", 0, mk(0, 0, 0, 0, 3'd4, 32'hC0, 1));
    for (int k = 0; k < 4; k++) begin
      chk("seq_drain.head", k, o_pdata, WIDTH'(32'hC0 + k));
      step(0, 0, 32'h0, 1);
      chk("seq_drain.count", k, WIDTH'(o_count), WIDTH'(3 - k));
    end
    chk("seq_drain.empty", 0, WIDTH'(o_empty), 32'h1);
    // slot 0 still holds C0; DEAD never overwrote it
    chk("seq_drain.stale", 0, o_pdata, 32'hC0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/common_fifo4.md
COMMON_FIFO4 -- requirements
Module: common_fifo4

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the data word width in bits.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  the reset; synchronous, active-high.
REQ-004 SHALL have port i_push  input  1  the push request.
REQ-005 SHALL have port i_pdata  input  WIDTH  the push data.
REQ-006 SHALL have port i_pop  input  1  the pop request.
REQ-007 SHALL have port o_pdata  output  WIDTH  the head-of-queue data, first-word-fall-through.
REQ-008 SHALL have port o_empty  output  1  asserted when occupancy is 0.
REQ-009 SHALL have port o_full  output  1  asserted when occupancy is 4.
REQ-010 SHALL have port o_count  output  3  the occupancy, 0..4.
REQ-011 SHALL have port o_err  output  1  the sticky overflow/underflow flag; present only with COMMON_FIFO4_ERRFLAG_EN.

Function
REQ-012 SHALL store up to 4 entries of WIDTH bits in a register array indexed by 2-bit pointers wptr and rptr.
REQ-013 SHALL advance wptr and rptr with the 2-bit increment of common_rtlrom_decinc2 (dec=0); 3 wraps to 0 and the carry is ignored.
REQ-014 SHALL update the 3-bit occupancy: +1 on an accepted push only, -1 on an accepted pop only, unchanged on both or neither.
REQ-015 SHALL accept a push iff i_push=1 and o_full=0, based on registered state at the start of the cycle.
REQ-016 SHALL accept a pop iff i_pop=1 and o_empty=0, based on registered state at the start of the cycle.
REQ-017 SHALL, on an accepted push, write i_pdata to mem[wptr] and advance wptr at the same edge.
REQ-018 SHALL, on an accepted pop, advance rptr at the edge; the entry is not cleared.
REQ-019 SHALL drive o_pdata = mem[rptr] combinationally; a pushed word appears on o_pdata one cycle after the push edge when the FIFO was empty.
REQ-020 SHALL derive o_empty = (count==0), o_full = (count==4), and o_count = count from registered state; no combinational path exists from i_push/i_pop to any status output.
REQ-021 SHALL ignore a push when full (no write, pointers and count unchanged, even if a pop is accepted the same cycle).
REQ-022 SHALL ignore a pop when empty (no bypass of same-cycle push data).
REQ-023 SHALL, on a simultaneous accepted push and pop at count 1..3, write and read distinct or wrapped slots correctly and leave the count unchanged.
REQ-024 SHALL never let count exceed 4 or underflow below 0.

Reset
REQ-025 SHALL, when reset=1 at a rising edge, set wptr=0, rptr=0, count=0 and all storage entries to 0, regardless of i_push/i_pop.
REQ-026 SHALL give, after reset, o_empty=1, o_full=0, o_count=0, o_pdata=0 and (if present) o_err=0.
REQ-027 SHALL discard all contents when reset is asserted mid-operation; the next cycle behaves as freshly reset.

Configuration
REQ-028 SHALL, with COMMON_FIFO4_ERRFLAG_EN defined, set o_err=1 at the edge following any cycle with i_push=1 & o_full=1 (overflow) or i_pop=1 & o_empty=1 (underflow); it clears only on reset.
REQ-029 SHALL, without COMMON_FIFO4_ERRFLAG_EN, omit the o_err port and its register entirely, with all other behaviour identical.

Verification
REQ-030 SHALL cover: reset, then push 0xA1,0xA2,0xA3,0xA4 on consecutive cycles -> o_count 1,2,3,4; o_full=1 after the 4th edge; o_pdata=0xA1.
REQ-031 SHALL cover: full FIFO, push 0xFF with pop -> only the pop is accepted; o_count=3; o_pdata=0xA2; 0xFF is never read.
REQ-032 SHALL cover: 10 cycles of simultaneous push/pop at count 2 with data 0..9 -> count stays 2, pointers wrap, and pops return the prior 2 entries then 0..7 in order.
REQ-033 SHALL cover: empty FIFO, pop with push 0x55 -> push only; o_count=1, o_pdata=0x55 next cycle; with the macro defined, o_err=1.
REQ-034 SHALL cover: count 3, assert reset with push=1 -> o_count=0, o_empty=1, o_pdata=0, o_err=0 next cycle.
